// File: rtl/signed_seq_div.sv
`default_nettype none
// ============================================================================
// signed_seq_div : multicycle signed divider, 2N-bit dividend / N-bit divisor,
// restoring shift-subtract on magnitudes with sign fix-up, saturation and
// divide-by-zero flags. Optional macro DIV_REMAINDER_EN builds the remainder path.
// Revision: 1.0
// ============================================================================
module signed_seq_div #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           ovf,
  output logic           dz
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [W-1:0]  POS_LIM   = W'((1 << (N - 1)) - 1);
  localparam logic [W-1:0]  NEG_LIM   = W'(1 << (N - 1));
  localparam logic [N-1:0]  Q_MAX     = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  Q_MIN     = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] ITER_LAST = CW'(W - 1);

  logic [2:0]    state_q,   state_d;
  logic [W-1:0]  op_dvd_q,  op_dvd_d;
  logic [N-1:0]  op_dsr_q,  op_dsr_d;
  logic [W-1:0]  acc_q,     acc_d;
  logic [N-1:0]  dsr_mag_q, dsr_mag_d;
  logic [N-1:0]  rem_q,     rem_d;
  logic          sgn_dvd_q, sgn_dvd_d;
  logic          sgn_dsr_q, sgn_dsr_d;
  logic          dz_pend_q, dz_pend_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic [N-1:0]  quo_q,     quo_d;
  logic          ovf_q,     ovf_d;
  logic          dz_q,      dz_d;
`ifdef DIV_REMAINDER_EN
  logic [N-1:0]  rmd_q,     rmd_d;
  logic [N-1:0]  w_r_twos;
`endif

  logic [N:0]    w_rem_shift;
  logic [N-1:0]  w_rem_sub;
  logic          w_fits;
  logic          w_q_neg;
  logic          w_ovf;
  logic [N-1:0]  w_q_twos;

  always_comb begin
    // Partial remainder stays below |divisor| <= 2^(N-1), so the shifted value fits N+1 bits
    // and a successful subtraction always fits N bits.
    w_rem_shift = {rem_q, acc_q[W-1]};
    w_rem_sub   = w_rem_shift[N-1:0] - dsr_mag_q;
    w_fits      = (w_rem_shift >= {1'b0, dsr_mag_q});
    w_q_neg     = sgn_dvd_q ^ sgn_dsr_q;
    w_ovf       = w_q_neg ? (acc_q > NEG_LIM) : (acc_q > POS_LIM);
    w_q_twos    = {N{1'b0}} - acc_q[N-1:0];
`ifdef DIV_REMAINDER_EN
    w_r_twos    = {N{1'b0}} - rem_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_dvd_d  = op_dvd_q;
    op_dsr_d  = op_dsr_q;
    acc_d     = acc_q;
    dsr_mag_d = dsr_mag_q;
    rem_d     = rem_q;
    sgn_dvd_d = sgn_dvd_q;
    sgn_dsr_d = sgn_dsr_q;
    dz_pend_d = dz_pend_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
`ifdef DIV_REMAINDER_EN
    rmd_d     = rmd_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_dvd_d = dividend;
          op_dsr_d = divisor;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        // Unsigned magnitudes: negating the most negative value yields 2^(W-1) as unsigned.
        sgn_dvd_d = op_dvd_q[W-1];
        sgn_dsr_d = op_dsr_q[N-1];
        acc_d     = op_dvd_q[W-1] ? ({W{1'b0}} - op_dvd_q) : op_dvd_q;
        dsr_mag_d = op_dsr_q[N-1] ? ({N{1'b0}} - op_dsr_q) : op_dsr_q;
        rem_d     = {N{1'b0}};
        cnt_d     = {CW{1'b0}};
        dz_pend_d = (op_dsr_q == {N{1'b0}});
        state_d   = (op_dsr_q == {N{1'b0}}) ? S_FIX : S_ITER;
      end

      S_ITER: begin
        // acc shifts the dividend out at the top and the quotient in at the bottom.
        rem_d = w_fits ? w_rem_sub : w_rem_shift[N-1:0];
        acc_d = {acc_q[W-2:0], w_fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (dz_pend_q) begin
          quo_d = sgn_dvd_q ? Q_MIN : Q_MAX;
          ovf_d = 1'b0;
          dz_d  = 1'b1;
`ifdef DIV_REMAINDER_EN
          rmd_d = {N{1'b0}};
`endif
        end else if (w_ovf) begin
          quo_d = w_q_neg ? Q_MIN : Q_MAX;
          ovf_d = 1'b1;
          dz_d  = 1'b0;
`ifdef DIV_REMAINDER_EN
          rmd_d = {N{1'b0}};
`endif
        end else begin
          quo_d = w_q_neg ? w_q_twos : acc_q[N-1:0];
          ovf_d = 1'b0;
          dz_d  = 1'b0;
`ifdef DIV_REMAINDER_EN
          rmd_d = sgn_dvd_q ? w_r_twos : rem_q;
`endif
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_dvd_q  <= {W{1'b0}};
      op_dsr_q  <= {N{1'b0}};
      acc_q     <= {W{1'b0}};
      dsr_mag_q <= {N{1'b0}};
      rem_q     <= {N{1'b0}};
      sgn_dvd_q <= 1'b0;
      sgn_dsr_q <= 1'b0;
      dz_pend_q <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      quo_q     <= {N{1'b0}};
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_dvd_q  <= op_dvd_d;
      op_dsr_q  <= op_dsr_d;
      acc_q     <= acc_d;
      dsr_mag_q <= dsr_mag_d;
      rem_q     <= rem_d;
      sgn_dvd_q <= sgn_dvd_d;
      sgn_dsr_q <= sgn_dsr_d;
      dz_pend_q <= dz_pend_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

`ifdef DIV_REMAINDER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rmd_q <= {N{1'b0}};
    end else begin
      rmd_q <= rmd_d;
    end
  end
  assign remainder = rmd_q;
`else
  assign remainder = {N{1'b0}};
`endif

  assign busy     = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign quotient = quo_q;
  assign ovf      = ovf_q;
  assign dz       = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_signed_seq_div.sv
`default_nettype none
// ============================================================================
// tb_signed_seq_div : randomized bench for signed_seq_div (N=4) against an
// integer-arithmetic reference model with per-cycle output comparison.
// Revision: 1.0
// ============================================================================
module tb_signed_seq_div;

  localparam int N = 4;
  localparam int W = 2 * N;
`ifdef DIV_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, ovf, dz;
  logic [N-1:0] quotient, remainder;

  int checks = 0;
  int passed = 0;

  signed_seq_div #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain signed integer division (truncates toward zero, remainder follows dividend).
  function automatic void model(input logic [W-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r,
                                output logic o, output logic z);
    int ia, ib, iq, ir;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) begin
      z = 1'b1; o = 1'b0; r = '0;
      q = (ia >= 0) ? 4'd7 : 4'd8;
    end else begin
      z  = 1'b0;
      iq = ia / ib;
      ir = ia % ib;
      if (iq > 7) begin
        o = 1'b1; q = 4'd7; r = '0;
      end else if (iq < -8) begin
        o = 1'b1; q = 4'd8; r = '0;
      end else begin
        o = 1'b0; q = iq[3:0]; r = ir[3:0];
      end
    end
  endfunction

  // Model of the operation in flight, advanced on every rising edge.
  bit           pending = 1'b0;
  int           cyc = 0;
  int           lat = 0;
  logic [N-1:0] pend_q, pend_r, hold_q = '0, hold_r = '0;
  logic         pend_o, pend_z, hold_o = 1'b0, hold_z = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      pending = 1'b0;
      cyc = 0;
      hold_q = '0; hold_r = '0; hold_o = 1'b0; hold_z = 1'b0;
    end else if (!pending) begin
      if (start) begin
        model(dividend, divisor, pend_q, pend_r, pend_o, pend_z);
        if (!REM_EN) pend_r = '0;
        lat = pend_z ? 3 : 2 * N + 3;
        pending = 1'b1;
        cyc = 0;
      end
    end else begin
      cyc++;
      if (cyc == lat - 1) begin
        hold_q = pend_q; hold_r = pend_r; hold_o = pend_o; hold_z = pend_z;
      end
      if (cyc == lat) pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outs", {busy, done, ovf, dz, quotient, remainder}, 32'd0);
    end else begin
      chk("done", done, (pending && cyc == lat - 1));
      chk("busy", busy, (pending && cyc < lat - 1));
      chk("results", {ovf, dz, quotient, remainder}, {hold_o, hold_z, hold_q, hold_r});
    end
  end

  // One operation; optionally pulses start again with other operands at negedge extra_at.
  task automatic do_op(input logic [W-1:0] a, input logic [N-1:0] b,
                       input int extra_at, input logic [W-1:0] a2, input logic [N-1:0] b2);
    int k;
    int exp_lat;
    exp_lat = (b == '0) ? 3 : 2 * N + 3;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start = (extra_at != 0 && k == extra_at);
      if (start) begin
        dividend = a2; divisor = b2;
      end else begin
        dividend = W'($urandom); divisor = N'($urandom);
      end
    end while (!done && k < 40);
    chk("done_seen", done, 1'b1);
    chk("latency", k, exp_lat);
  endtask

  task automatic chk_model(input string name, input logic [W-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] eq, input logic [N-1:0] er,
                           input logic eo, input logic ez);
    logic [N-1:0] q, r;
    logic o, z;
    model(a, b, q, r, o, z);
    chk(name, {q, r, o, z}, {eq, er, eo, ez});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, checks);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] a, a2;
    logic [N-1:0] b, b2;
    logic [W-1:0] edge_vals [4];
    edge_vals[0] = 8'h80; edge_vals[1] = 8'h7F; edge_vals[2] = 8'h00; edge_vals[3] = 8'hFF;

    chk_model("m_45_6",    8'h2D, 4'h6, 4'h7, 4'h3, 1'b0, 1'b0);
    chk_model("m_n45_6",   8'hD3, 4'h6, 4'h9, 4'hD, 1'b0, 1'b0);
    chk_model("m_45_n6",   8'h2D, 4'hA, 4'h9, 4'h3, 1'b0, 1'b0);
    chk_model("m_n56_7",   8'hC8, 4'h7, 4'h8, 4'h0, 1'b0, 1'b0);
    chk_model("m_n128_n1", 8'h80, 4'hF, 4'h7, 4'h0, 1'b1, 1'b0);
    chk_model("m_100_0",   8'h64, 4'h0, 4'h7, 4'h0, 1'b0, 1'b1);
    chk_model("m_n1_0",    8'hFF, 4'h0, 4'h8, 4'h0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_op(8'h2D, 4'h6, 0, '0, '0);
    do_op(8'hD3, 4'h6, 0, '0, '0);
    do_op(8'h2D, 4'hA, 0, '0, '0);
    do_op(8'hC8, 4'h7, 0, '0, '0);
    do_op(8'h80, 4'hF, 0, '0, '0);
    do_op(8'h64, 4'h0, 0, '0, '0);
    do_op(8'h80, 4'h8, 0, '0, '0);
    // Second start while busy, and another during the done cycle: both ignored.
    do_op(8'h2D, 4'h6, 3, 8'h80, 4'h1);
    do_op(8'hD3, 4'h6, 11, 8'h64, 4'h0);

    // Reset mid-operation.
    @(negedge clk);
    dividend = 8'hD3; divisor = 4'h6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    do_op(8'h2D, 4'h6, 0, '0, '0);

    repeat (200) begin
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 4'h0 : N'($urandom);
      a2 = W'($urandom);
      b2 = N'($urandom);
      do_op(a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0, a2, b2);
    end

    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
